// File: rtl/sum_display_scanner.sv
// sum_display_scanner
//   Shows the adder result {carry-out, SUM[3:0]} as a decimal number on a
//   4-digit, common-anode seven-segment display.
//   - A double-dabble engine converts the binary value to BCD. It runs one
//     iteration per cycle behind a load/busy/done handshake.
//   - A refresh counter multiplexes the four digits in time.
//   - Leading-zero digits can be blanked. Digit 0 is never blanked.
//
// Ports
//   clk     system clock, rising edge
//   rst     synchronous, active-high reset
//   sum_in  binary value to display (MSB is the adder carry-out)
//   load    single-cycle request to capture sum_in and start a conversion
//   busy    high while a conversion is in progress
//   done    one-cycle pulse when the new value reaches the display register
//   seg     segment drive, active-low, {g,f,e,d,c,b,a}
//   an      digit enables, active-low, an[0] = ones digit
//   dp      decimal point, active-low, always off
module sum_display_scanner #(
  parameter int IN_WIDTH    = 5,
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_WIDTH-1:0] sum_in,
  input  logic                load,
  output logic                busy,
  output logic                done,
  output logic [6:0]          seg,
  output logic [3:0]          an,
  output logic                dp
);

  localparam int CNT_W  = $clog2(REFRESH_DIV);
  localparam int ITER_W = 4;

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  state_t state_reg, state_next;

  logic [IN_WIDTH-1:0]    bin_reg;
  logic [15:0]            bcd_reg;
  logic [15:0]            bcd_adj;
  logic [IN_WIDTH+15:0]   shifted;
  logic [ITER_W-1:0]      iter_reg;
  logic [15:0]            display_reg;
  logic                   busy_reg;
  logic                   done_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [1:0]             idx_reg;
  logic [3:0]             blank;
  logic [3:0]             an_reg;
  logic [6:0]             seg_reg;

  // Double-dabble step: add 3 to every nibble >= 5, then shift {bcd, bin}.
  // The MSB of the BCD field falls off the top of the shift; it is always
  // zero because the input range fits in four BCD digits.
  for (genvar gi = 0; gi < 4; gi++) begin : g_adj
    assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5)
                              ? bcd_reg[gi*4 +: 4] + 4'd3
                              : bcd_reg[gi*4 +: 4];
  end

  assign shifted = {bcd_adj, bin_reg} << 1;

  // Converter FSM
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (load) state_next = CONVERT;
      CONVERT: if (iter_reg == ITER_W'(IN_WIDTH - 1)) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Converter datapath. The display register only changes in COMMIT, so a
  // conversion in progress never shows a partial value.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_reg     <= '0;
      bcd_reg     <= '0;
      iter_reg    <= '0;
      display_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      busy_reg <= (state_next != IDLE);
      done_reg <= (state_reg == COMMIT);
      case (state_reg)
        IDLE: begin
          if (load) begin
            bin_reg  <= sum_in;
            bcd_reg  <= '0;
            iter_reg <= '0;
          end
        end
        CONVERT: begin
          bcd_reg  <= shifted[IN_WIDTH+15:IN_WIDTH];
          bin_reg  <= shifted[IN_WIDTH-1:0];
          iter_reg <= iter_reg + 1'b1;
        end
        COMMIT: display_reg <= bcd_reg;
        default: ;
      endcase
    end
  end

  // Refresh timer: each digit stays lit for REFRESH_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      idx_reg <= '0;
    end else if (cnt_reg == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_reg <= '0;
      idx_reg <= idx_reg + 1'b1;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Digit k > 0 is blank when it and every higher digit are zero.
  assign blank[0] = 1'b0;
  for (genvar gi = 1; gi < 4; gi++) begin : g_blank
    assign blank[gi] = BLANK_LZ && (display_reg[15:gi*4] == '0);
  end

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0011000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  // Output drive, registered from the current digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_reg  <= 4'b1111;
      seg_reg <= 7'b1111111;
    end else if (blank[idx_reg]) begin
      an_reg  <= 4'b1111;
      seg_reg <= 7'b1111111;
    end else begin
      an_reg  <= ~(4'b0001 << idx_reg);
      seg_reg <= decode(display_reg[idx_reg*4 +: 4]);
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign an   = an_reg;
  assign seg  = seg_reg;
  assign dp   = 1'b1;

endmodule

// File: tb/tb_sum_display_scanner.sv
module tb_sum_display_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] sum_a = '0, sum_b = '0;
  logic       load_a = 1'b0, load_b = 1'b0;
  logic       busy_a, done_a, dp_a, busy_b, done_b, dp_b;
  logic [6:0] seg_a, seg_b;
  logic [3:0] an_a, an_b;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S9 = 7'b0011000;
  localparam logic [6:0] SB = 7'b1111111;

  always #5 clk = ~clk;

  sum_display_scanner #(.IN_WIDTH(5), .REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .rst(rst), .sum_in(sum_a), .load(load_a),
    .busy(busy_a), .done(done_a), .seg(seg_a), .an(an_a), .dp(dp_a));

  sum_display_scanner #(.IN_WIDTH(5), .REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_b (
    .clk(clk), .rst(rst), .sum_in(sum_b), .load(load_b),
    .busy(busy_b), .done(done_b), .seg(seg_b), .an(an_b), .dp(dp_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  // Watch one full scan period (4 digits x 4 cycles) and check which digits
  // light and what each one shows.
  task automatic scan(input string tag, input bit sel, input logic [3:0] exp_seen,
                      input logic [6:0] e0, input logic [6:0] e1,
                      input logic [6:0] e2, input logic [6:0] e3);
    logic [3:0] seen;
    logic [6:0] segs [4];
    logic [6:0] exp_seg [4];
    logic [3:0] a;
    logic [6:0] s;
    int bad_an;
    seen = '0;
    bad_an = 0;
    exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
    for (int k = 0; k < 4; k++) segs[k] = SB;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      a = sel ? an_b : an_a;
      s = sel ? seg_b : seg_a;
      case (a)
        4'b1110: begin seen[0] = 1'b1; segs[0] = s; end
        4'b1101: begin seen[1] = 1'b1; segs[1] = s; end
        4'b1011: begin seen[2] = 1'b1; segs[2] = s; end
        4'b0111: begin seen[3] = 1'b1; segs[3] = s; end
        4'b1111: if (s !== SB) bad_an++;
        default: bad_an++;
      endcase
    end
    check({tag, " digits lit"}, 32'(seen), 32'(exp_seen));
    check({tag, " an/seg legal"}, 32'(bad_an), 32'd0);
    for (int k = 0; k < 4; k++)
      if (exp_seen[k]) check($sformatf("%s seg[%0d]", tag, k), 32'(segs[k]), 32'(exp_seg[k]));
    $display("scan %s: digits lit %b", tag, seen);
  endtask

  // Issue a load on DUT A, then measure busy length and the done pulse.
  task automatic convert_a(input string tag, input logic [4:0] v);
    int busy_cycles;
    @(negedge clk);
    sum_a = v; load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
    busy_cycles = 0;
    while (busy_a && busy_cycles < 20) begin
      busy_cycles++;
      @(negedge clk);
    end
    check({tag, " busy cycles"}, 32'(busy_cycles), 32'd6);
    check({tag, " done at busy drop"}, 32'(done_a), 32'd1);
    @(negedge clk);
    check({tag, " done one cycle"}, 32'(done_a), 32'd0);
    $display("convert %s: value %0d, busy %0d cycles", tag, v, busy_cycles);
  endtask

  initial begin
    int dones;
    repeat (3) @(negedge clk);
    check("reset an", 32'(an_a), 32'hF);
    check("reset seg", 32'(seg_a), 32'(SB));
    check("reset busy", 32'(busy_a), 32'd0);
    check("reset done", 32'(done_a), 32'd0);
    check("reset dp", 32'(dp_a), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("first an", 32'(an_a), 32'hE);
    check("first seg", 32'(seg_a), 32'(S0));
    scan("idle", 1'b0, 4'b0001, S0, SB, SB, SB);

    convert_a("31", 5'd31);
    scan("31", 1'b0, 4'b0011, S1, S3, SB, SB);

    convert_a("10", 5'd10);
    scan("10", 1'b0, 4'b0011, S0, S1, SB, SB);

    // Second load two cycles after the first must be ignored.
    @(negedge clk);
    sum_a = 5'd31; load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
    @(negedge clk);
    sum_a = 5'd7; load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done_a) dones++;
    end
    check("overlap done count", 32'(dones), 32'd1);
    $display("overlap load: done pulses %0d", dones);
    scan("overlap", 1'b0, 4'b0011, S1, S3, SB, SB);

    // Reset in the middle of a conversion.
    @(negedge clk);
    sum_a = 5'd25; load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
    @(negedge clk);
    check("abort busy before rst", 32'(busy_a), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 32'(busy_a), 32'd0);
    check("abort done", 32'(done_a), 32'd0);
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done_a) dones++;
    end
    check("abort no done", 32'(dones), 32'd0);
    $display("abort: done pulses %0d", dones);
    scan("abort", 1'b0, 4'b0001, S0, SB, SB, SB);

    // No blanking: all four digits driven.
    @(negedge clk);
    sum_b = 5'd9; load_b = 1'b1;
    @(negedge clk);
    load_b = 1'b0;
    repeat (10) @(negedge clk);
    scan("noblank 9", 1'b1, 4'b1111, S9, S0, S0, S0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
